// File: rtl/npu_pkg.sv
// Shared NPU definitions: activation width and the pixel type carried
// through the convolution front end.
package npu_pkg;

  localparam int ACT_W = 8;

  typedef logic [ACT_W-1:0] pixel_t;

endpackage : npu_pkg

// File: rtl/line_buffer.sv
// One image row of delay storage. The byte read at addr_i is the pixel
// written one row earlier at the same column; the incoming byte replaces it
// on the same edge, so each write shifts the row by one image line.
module line_buffer
  import npu_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pixel_t        din_i,
  output pixel_t        dout_o
);

  // Contents are never reset: every location is rewritten before a window
  // can depend on it.
  pixel_t mem_q [DEPTH];

  // Read-before-write: dout_o shows the previous row's pixel at this column.
  assign dout_o = mem_q[addr_i];

  // Store the incoming pixel at the current column.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

endmodule : line_buffer

// File: rtl/conv_window_gen.sv
// Streaming K_H x K_W sliding-window generator for the convolution MAC.
// Takes one raster-order pixel per cycle, keeps K_H-1 previous rows in line
// buffers and emits every valid (unpadded) window in row-major order.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, data is held while valid && !ready.
// Input side: in_ready = !win_valid || win_ready, because there is a single
// output register and a pixel may complete a window that needs it.
//
// Requires K_H >= 2 (at least one line buffer).
module conv_window_gen
  import npu_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K_H   = 3,
  parameter int K_W   = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  pixel_t in_data,
  output logic   win_valid,
  input  logic   win_ready,
  output pixel_t conv_win [K_H][K_W],
  output logic   frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K_W - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          last_q, last_d;
  pixel_t        sr_q  [K_H][K_W];
  pixel_t        sr_d  [K_H][K_W];
  pixel_t        win_q [K_H][K_W];
  pixel_t        win_d [K_H][K_W];
  pixel_t        lb_out [K_H-1];

  logic accept;
  logic emit;
  logic is_last_px;

  assign in_ready   = !win_valid_q || win_ready;
  assign accept     = in_valid && in_ready;
  assign is_last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);
  // A window needs K_H rows and K_W fresh pixels of the current row, so
  // columns left over from the previous row can never be emitted.
  assign emit       = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);

  // Line buffer chain: index 0 holds the oldest row, K_H-2 the row just above.
  for (genvar k = 0; k < K_H - 1; k++) begin : g_lb
    pixel_t din;
    if (k == K_H - 2) begin : g_newest
      assign din = in_data;
    end else begin : g_older
      assign din = lb_out[k+1];
    end
    line_buffer #(
      .DEPTH (IMG_W),
      .AW    (CW)
    ) u_lb (
      .clk    (clk),
      .we_i   (accept),
      .addr_i (col_q),
      .din_i  (din),
      .dout_o (lb_out[k])
    );
  end

  // Raster position of the next pixel; wraps straight into the next frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Column shift register: shift left, new right column from the line
  // buffers (older rows on top) with the incoming pixel at the bottom.
  always_comb begin
    sr_d = sr_q;
    if (accept) begin
      for (int r = 0; r < K_H; r++) begin
        for (int c = 0; c < K_W - 1; c++) begin
          sr_d[r][c] = sr_q[r][c+1];
        end
      end
      for (int r = 0; r < K_H - 1; r++) begin
        sr_d[r][K_W-1] = lb_out[r];
      end
      sr_d[K_H-1][K_W-1] = in_data;
    end
  end

  // Output register: load on emit (even while the old window is consumed),
  // otherwise drop the window once downstream takes it.
  always_comb begin
    win_d       = win_q;
    win_valid_d = win_valid_q;
    last_d      = last_q;
    if (emit) begin
      win_d       = sr_d;
      win_valid_d = 1'b1;
      last_d      = is_last_px;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      last_d      = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      last_q      <= 1'b0;
      for (int r = 0; r < K_H; r++) begin
        for (int c = 0; c < K_W; c++) begin
          sr_q[r][c]  <= '0;
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      last_q      <= last_d;
      sr_q        <= sr_d;
      win_q       <= win_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign conv_win   = win_q;
  assign frame_done = win_valid_q && win_ready && last_q;

endmodule : conv_window_gen

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 5x5 instance for directed/stall/reset/random
// phases and a 28x28 instance for the full-size ramp.
module tb_conv_window_gen;
  import npu_pkg::*;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int BW = 28;
  localparam int BH = 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- small DUT ----------------
  logic   in_valid = 1'b0;
  logic   in_ready;
  pixel_t in_data = '0;
  logic   win_valid;
  logic   win_ready = 1'b1;
  pixel_t conv_win [3][3];
  logic   frame_done;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .K_H(3), .K_W(3)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .conv_win   (conv_win),
    .frame_done (frame_done)
  );

  // ---------------- large DUT ----------------
  logic   b_in_valid = 1'b0;
  logic   b_in_ready;
  pixel_t b_in_data = '0;
  logic   b_win_valid;
  logic   b_win_ready = 1'b1;
  pixel_t b_conv_win [3][3];
  logic   b_frame_done;

  conv_window_gen #(.IMG_W(BW), .IMG_H(BH), .K_H(3), .K_W(3)) u_dut_big (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_data    (b_in_data),
    .win_valid  (b_win_valid),
    .win_ready  (b_win_ready),
    .conv_win   (b_conv_win),
    .frame_done (b_frame_done)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [72:0] exp_q [$];   // {last, window}, window [0][0] in the low byte
  logic [72:0] got_q [$];
  logic [72:0] ref_q [$];
  int n_fd = 0;
  int b_n  = 0;
  int b_fd = 0;
  int ready_mode = 0;       // 0 always ready, 1 random, 2 one 4-cycle stall
  int stall_cnt  = 0;

  logic [71:0] dut_flat, b_flat;
  always_comb begin
    dut_flat = '0;
    b_flat   = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        dut_flat[(i*3+j)*8 +: 8] = conv_win[i][j];
        b_flat[(i*3+j)*8 +: 8]   = b_conv_win[i][j];
      end
    end
  end

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-written window literal: three row starts, each row is s, s+1, s+2.
  function automatic logic [71:0] lit(input int r0, input int r1, input int r2);
    logic [71:0] v;
    int s [3];
    s[0] = r0; s[1] = r1; s[2] = r2;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[(i*3+j)*8 +: 8] = 8'(s[i] + j);
    return v;
  endfunction

  // Reference model: the image is pixel(r,c) = base + W*r + c; every output
  // position whose bottom-right pixel index is <= limit yields a window.
  task automatic push_frame(input int base, input int limit);
    logic [72:0] e;
    for (int orow = 0; orow <= H - 3; orow++) begin
      for (int ocol = 0; ocol <= W - 3; ocol++) begin
        if ((orow + 2) * W + ocol + 2 <= limit) begin
          e = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e[(i*3+j)*8 +: 8] = 8'(base + (orow + i) * W + ocol + j);
          e[72] = (orow == H - 3) && (ocol == W - 3);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // ---------------- downstream ready control ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: win_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (stall_cnt > 0 && stall_cnt < 4) begin
          win_ready = 1'b0;
          stall_cnt++;
        end else if (stall_cnt == 0 && win_valid) begin
          win_ready = 1'b0;
          stall_cnt = 1;
        end else begin
          win_ready = 1'b1;
        end
      end
      default: win_ready = 1'b1;
    endcase
  end

  // ---------------- compare process, small DUT ----------------
  logic [71:0] prev_win;
  logic        prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", {72'd0, in_ready}, {72'd0, (!win_valid || win_ready)});
      if (prev_stall) begin
        check("hold_valid", {72'd0, win_valid}, 73'd1);
        check("hold_window", {1'b0, dut_flat}, {1'b0, prev_win});
      end
      if (win_valid && win_ready) begin
        got_q.push_back({frame_done, dut_flat});
        if (frame_done) n_fd++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_window: got %h expected none", {frame_done, dut_flat});
        end else begin
          check("window", {frame_done, dut_flat}, exp_q.pop_front());
        end
      end else if (frame_done) begin
        check("frame_done_idle", 73'd1, 73'd0);
      end
      prev_stall = win_valid && !win_ready;
      prev_win   = dut_flat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- compare process, large DUT ----------------
  always @(negedge clk) begin
    if (rst_n && b_win_valid) begin
      logic [72:0] e;
      int orow, ocol;
      orow = b_n / (BW - 2);
      ocol = b_n % (BW - 2);
      e = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e[(i*3+j)*8 +: 8] = 8'((orow + i) * BW + ocol + j);
      e[72] = (b_n == (BW - 2) * (BH - 2) - 1);
      check("big_window", {b_frame_done, b_flat}, e);
      if (b_frame_done) b_fd++;
      b_n++;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_px(input pixel_t d, input bit gaps);
    bit acc;
    int budget;
    if (gaps) begin
      in_valid = 1'b0;
      idle($urandom_range(0, 2));
    end
    in_valid = 1'b1;
    in_data  = d;
    budget   = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      budget++;
      if (budget > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 50 cycles");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input int npix, input bit gaps);
    for (int p = 0; p < npix; p++) send_px(8'(base + p), gaps);
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      idle(1);
      budget++;
    end
    idle(3);
    check("drain_empty", 73'(exp_q.size()), 73'd0);
  endtask

  task automatic new_phase(input int mode);
    got_q.delete();
    n_fd       = 0;
    stall_cnt  = 0;
    ready_mode = mode;
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {72'd0, in_ready}, 73'd1);
    check({tag, "_win_valid"}, {72'd0, win_valid}, 73'd0);
    check({tag, "_frame_done"}, {72'd0, frame_done}, 73'd0);
    check({tag, "_conv_win"}, {1'b0, dut_flat}, 73'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle(2);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // A: ramp frame, always ready
    new_phase(0);
    push_frame(0, W * H - 1);
    send_frame(0, W * H, 1'b0);
    drain();
    check("a_count", 73'(got_q.size()), 73'd9);
    if (got_q.size() == 9) begin
      check("a_first", got_q[0], {1'b0, lit(0, 5, 10)});
      check("a_last", got_q[8], {1'b1, lit(12, 17, 22)});
    end
    check("a_frame_done", 73'(n_fd), 73'd1);
    ref_q = got_q;

    // B: same frame with a 4-cycle stall at the first window
    new_phase(2);
    push_frame(0, W * H - 1);
    send_frame(0, W * H, 1'b0);
    drain();
    check("b_count", 73'(got_q.size()), 73'(ref_q.size()));
    for (int k = 0; k < got_q.size() && k < ref_q.size(); k++)
      check("b_same_as_a", got_q[k], ref_q[k]);
    check("b_stalled", 73'(stall_cnt), 73'd4);

    // C: two back-to-back frames, second offset by 100
    new_phase(0);
    push_frame(0, W * H - 1);
    push_frame(100, W * H - 1);
    send_frame(0, W * H, 1'b0);
    send_frame(100, W * H, 1'b0);
    drain();
    check("c_count", 73'(got_q.size()), 73'd18);
    if (got_q.size() == 18)
      check("c_second_first", got_q[9], {1'b0, lit(100, 105, 110)});
    check("c_frame_done", 73'(n_fd), 73'd2);

    // D: random input gaps and random downstream ready, three frames
    new_phase(1);
    for (int f = 0; f < 3; f++) begin
      push_frame(30 * f, W * H - 1);
      send_frame(30 * f, W * H, 1'b1);
    end
    ready_mode = 1;
    drain();
    ready_mode = 0;
    drain();
    check("d_frame_done", 73'(n_fd), 73'd3);

    // E: reset after pixel 17, then a clean frame
    new_phase(0);
    push_frame(50, 17);
    send_frame(50, 18, 1'b0);
    drain();
    check("e_partial_count", 73'(got_q.size()), 73'd4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle(2);
    rst_n = 1'b1;
    new_phase(0);
    push_frame(0, W * H - 1);
    send_frame(0, W * H, 1'b0);
    drain();
    check("e_count", 73'(got_q.size()), 73'(ref_q.size()));
    for (int k = 0; k < got_q.size() && k < ref_q.size(); k++)
      check("e_same_as_a", got_q[k], ref_q[k]);

    // F: full-size 28x28 ramp on the large instance
    for (int p = 0; p < BW * BH; p++) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'(p % BW + (p / BW) * BW);
      @(negedge clk);
      if (!b_in_ready) check("big_in_ready", 73'd0, 73'd1);
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    idle(4);
    check("big_count", 73'(b_n), 73'd676);
    check("big_frame_done", 73'(b_fd), 73'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_conv_window_gen
